pipeline_arbiter: RTL and testbench

Round-robin arbiter that merges N valid/ready requester streams into one valid/ready sink. It uses the same data/valid/ready handshake as the pipeline stages, with one registered output stage. The block sits in front of a shared `pipeline` instance or any single-consumer datapath. Each grant is held for a bounded burst, so one requester can push several consecutive words before the arbiter rotates to the next.

---
 rtl/pipeline_arbiter_if.sv | 28 ++
 rtl/pipeline_arbiter.sv | 114 +++++++++++
 tb/tb_pipeline_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_arbiter_if.sv
// rtl/pipeline_arbiter_if.sv - requester/sink handshake bundle for pipeline_arbiter
// master = requesters plus downstream consumer, slave = arbiter.
interface pipeline_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  localparam int ID_W = $clog2(N);

  logic [N*WIDTH-1:0] src_data;
  logic [N-1:0]       src_valid;
  logic [N-1:0]       src_ready;
  logic [WIDTH-1:0]   sink_data;
  logic               sink_valid;
  logic               sink_ready;
  logic [ID_W-1:0]    sink_id;
  logic               grant_active;
  logic [ID_W-1:0]    grant_id;

  modport master (
    output src_data, src_valid, sink_ready,
    input  src_ready, sink_data, sink_valid, sink_id, grant_active, grant_id
  );

  modport slave (
    input  src_data, src_valid, sink_ready,
    output src_ready, sink_data, sink_valid, sink_id, grant_active, grant_id
  );
endinterface

// File: rtl/pipeline_arbiter.sv
// rtl/pipeline_arbiter.sv - round-robin burst arbiter merging N valid/ready streams
// into one registered valid/ready sink.
module pipeline_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  pipeline_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_next;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  pick_id;
  logic [ID_W-1:0]  grant_succ;
  logic [CNT_W-1:0] burst_cnt;
  logic             pick_found;
  logic             load_en;
  logic             xfer;
  logic             last_beat;
  logic             release_grant;
  logic [WIDTH-1:0] sink_data_q;
  logic             sink_valid_q;
  logic [ID_W-1:0]  sink_id_q;

  assign load_en       = !sink_valid_q || bus.sink_ready;
  assign xfer          = (state == GRANT) && load_en && bus.src_valid[grant_id];
  assign last_beat     = xfer && (burst_cnt == CNT_W'(MAX_BURST - 1));
  assign release_grant = (state == GRANT) && load_en && (!bus.src_valid[grant_id] || last_beat);
  assign grant_succ    = (grant_id == ID_W'(N - 1)) ? '0 : grant_id + ID_W'(1);

  // First valid requester at or after ptr, wrapping past N-1.
  always_comb begin
    int j;
    logic [ID_W-1:0] jj;
    j          = 0;
    jj         = '0;
    pick_found = 1'b0;
    pick_id    = ptr;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = ID_W'(j);
      if (!pick_found && bus.src_valid[jj]) begin
        pick_found = 1'b1;
        pick_id    = jj;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found) state_next = GRANT;
      GRANT:   if (release_grant) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      if (state == IDLE && pick_found) begin
        grant_id  <= pick_id;
        burst_cnt <= '0;
      end else if (xfer) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end
      if (release_grant) ptr <= grant_succ;
    end
  end

  // Output word is held whenever the sink stalls a valid word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sink_data_q  <= '0;
      sink_valid_q <= 1'b0;
      sink_id_q    <= '0;
    end else if (load_en) begin
      if (xfer) begin
        sink_data_q  <= bus.src_data[int'(grant_id)*WIDTH +: WIDTH];
        sink_id_q    <= grant_id;
        sink_valid_q <= 1'b1;
      end else begin
        sink_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.src_ready = '0;
    if (state == GRANT) bus.src_ready[grant_id] = load_en;
    bus.grant_active = (state == GRANT);
  end

  assign bus.grant_id   = grant_id;
  assign bus.sink_data  = sink_data_q;
  assign bus.sink_valid = sink_valid_q;
  assign bus.sink_id    = sink_id_q;
endmodule

// File: tb/tb_pipeline_arbiter.sv
// tb/tb_pipeline_arbiter.sv - directed bench for pipeline_arbiter, burst 4 and burst 2
// instances driven by identical stimulus and checked against a transaction-level model.
module tb_pipeline_arbiter;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic         sink_ready;
  int           tick;
  bit           auto_data;
  bit           cmp_on;
  int           n_vec;
  int           n_err;

  always #5 clk = ~clk;

  pipeline_arbiter_if #(.N(4), .WIDTH(32)) b4 ();
  pipeline_arbiter_if #(.N(4), .WIDTH(32)) b2 ();

  assign b4.src_data   = src_data;
  assign b4.src_valid  = src_valid;
  assign b4.sink_ready = sink_ready;
  assign b2.src_data   = src_data;
  assign b2.src_valid  = src_valid;
  assign b2.sink_ready = sink_ready;

  pipeline_arbiter #(.N(4), .WIDTH(32), .MAX_BURST(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  pipeline_arbiter #(.N(4), .WIDTH(32), .MAX_BURST(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  typedef struct packed {
    logic        busy;
    logic [1:0]  gid;
    logic [1:0]  ptr;
    logic [3:0]  cnt;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  oid;
  } mstate_t;

  mstate_t ms [2];

  // Who owns the sink, how many words it has pushed, and what word sits at the output.
  function automatic mstate_t model_next(input mstate_t s, input int mb, input logic [3:0] v,
                                         input logic [127:0] d, input logic rdy);
    mstate_t n;
    logic    free;
    bit      found;
    int      j;
    n     = s;
    free  = !s.ov || rdy;
    found = 0;
    if (free) n.ov = 1'b0;
    if (s.busy) begin
      if (free) begin
        if (v[s.gid]) begin
          n.ov  = 1'b1;
          n.od  = d[int'(s.gid)*32 +: 32];
          n.oid = s.gid;
          n.cnt = s.cnt + 4'd1;
          if (n.cnt == 4'(mb)) begin
            n.busy = 1'b0;
            n.ptr  = s.gid + 2'd1;
          end
        end else begin
          n.busy = 1'b0;
          n.ptr  = s.gid + 2'd1;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        j = (int'(s.ptr) + k) % 4;
        if (!found && v[j]) begin
          found  = 1;
          n.busy = 1'b1;
          n.cnt  = 4'd0;
          n.gid  = 2'(j);
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms[0] <= '0;
      ms[1] <= '0;
    end else begin
      ms[0] <= model_next(ms[0], 4, src_valid, src_data, sink_ready);
      ms[1] <= model_next(ms[1], 2, src_valid, src_data, sink_ready);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int m, input logic [3:0] sr, input logic sv, input logic [31:0] sd,
                           input logic [1:0] sid, input logic ga, input logic [1:0] gi);
    mstate_t    s;
    logic [3:0] exp_sr;
    s      = ms[m];
    exp_sr = (s.busy && (!s.ov || sink_ready)) ? (4'b0001 << s.gid) : 4'b0000;
    chk($sformatf("m%0d src_ready", m), 32'(sr), 32'(exp_sr));
    chk($sformatf("m%0d sink_valid", m), 32'(sv), 32'(s.ov));
    chk($sformatf("m%0d sink_data", m), sd, s.od);
    chk($sformatf("m%0d sink_id", m), 32'(sid), 32'(s.oid));
    chk($sformatf("m%0d grant_active", m), 32'(ga), 32'(s.busy));
    chk($sformatf("m%0d grant_id", m), 32'(gi), 32'(s.gid));
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check_dut(0, b4.src_ready, b4.sink_valid, b4.sink_data, b4.sink_id, b4.grant_active, b4.grant_id);
      check_dut(1, b2.src_ready, b2.sink_valid, b2.sink_data, b2.sink_id, b2.grant_active, b2.grant_id);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    tick++;
    if (auto_data)
      for (int i = 0; i < 4; i++) src_data[i*32 +: 32] = {4'(i), 28'(tick)};
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    int ids[$];
    int gaps;
    int exp_ids[9];
    logic [31:0] snap;
    n_vec = 0; n_err = 0; tick = 0; auto_data = 0;
    src_data = '0; src_valid = '0; sink_ready = 1'b1;
    cmp_on = 1;
    #2 reset = 1'b0;
    repeat (2) step();
    chk("rst sink_valid", 32'(b4.sink_valid), 0);
    chk("rst grant_active", 32'(b4.grant_active), 0);
    chk("rst src_ready", 32'(b4.src_ready), 0);
    chk("rst sink_data", b4.sink_data, 0);
    reset = 1'b1;

    // Requester 2 alone, words A,B,C
    src_valid = 4'b0100;
    src_data[64 +: 32] = 32'h0000_00A1;
    step();
    chk("t1 src_ready", 32'(b4.src_ready), 32'h4);
    chk("t1 early valid", 32'(b4.sink_valid), 0);
    step();
    chk("t1 A valid", 32'(b4.sink_valid), 1);
    chk("t1 A data", b4.sink_data, 32'h0000_00A1);
    chk("t1 A id", 32'(b4.sink_id), 2);
    src_data[64 +: 32] = 32'h0000_00B2;
    step();
    chk("t1 B data", b4.sink_data, 32'h0000_00B2);
    src_data[64 +: 32] = 32'h0000_00C3;
    step();
    chk("t1 C data", b4.sink_data, 32'h0000_00C3);
    chk("t1 C id", 32'(b4.sink_id), 2);
    src_valid = 4'b0000;
    step();
    chk("t1 released", 32'(b4.grant_active), 0);
    chk("t1 drained", 32'(b4.sink_valid), 0);

    // All four continuously valid on the burst-2 instance
    do_reset();
    auto_data = 1;
    src_valid = 4'b1111;
    gaps = 0;
    exp_ids = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    for (int c = 0; c < 16; c++) begin
      step();
      chk("t2 onehot m2", 32'($countones(b2.src_ready) <= 1), 1);
      chk("t2 onehot m4", 32'($countones(b4.src_ready) <= 1), 1);
      if (b2.sink_valid) ids.push_back(int'(b2.sink_id));
      else if (ids.size() > 0 && ids.size() < 9) gaps++;
    end
    chk("t2 word count", 32'(ids.size() >= 9), 1);
    for (int i = 0; i < 9 && i < ids.size(); i++)
      chk($sformatf("t2 order[%0d]", i), 32'(ids[i]), 32'(exp_ids[i]));
    chk("t2 idle gaps", 32'(gaps), 4);

    // Back-pressure mid-burst on requester 1
    do_reset();
    src_valid = 4'b0010;
    repeat (3) step();
    sink_ready = 1'b0;
    snap = b4.sink_data;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t3 held data", b4.sink_data, snap);
      chk("t3 held id", 32'(b4.sink_id), 1);
      chk("t3 no ready", 32'(b4.src_ready), 0);
      chk("t3 grant kept", 32'(b4.grant_id), 1);
    end
    sink_ready = 1'b1;
    repeat (5) step();
    src_valid = 4'b0000;
    repeat (2) step();

    // Wrap-around: 3 granted last, then 0 and 3 compete
    do_reset();
    auto_data = 0;
    src_valid = 4'b1000;
    step();
    chk("t4 grant 3", 32'(b4.grant_id), 3);
    step();
    src_valid = 4'b0000;
    step();
    src_valid = 4'b1001;
    step();
    chk("t4 wrap m4", 32'(b4.grant_id), 0);
    chk("t4 wrap m2", 32'(b2.grant_id), 0);
    src_valid = 4'b0000;
    repeat (2) step();

    // Requester 1 goes idle after one word, requester 2 waiting
    do_reset();
    src_valid = 4'b0110;
    step();
    chk("t5 grant 1", 32'(b4.grant_id), 1);
    step();
    src_valid = 4'b0100;
    step();
    chk("t5 release", 32'(b4.grant_active), 0);
    step();
    chk("t5 regrant", 32'(b4.grant_active), 1);
    chk("t5 grant 2", 32'(b4.grant_id), 2);
    src_valid = 4'b0000;
    repeat (3) step();

    // Asynchronous reset with a word held at the output
    do_reset();
    src_valid = 4'b0100;
    src_data[64 +: 32] = 32'hDEAD_BEEF;
    repeat (2) step();
    chk("t6 pre valid", 32'(b4.sink_valid), 1);
    chk("t6 pre data", b4.sink_data, 32'hDEAD_BEEF);
    #2 reset = 1'b0;
    #1;
    chk("t6 rst valid", 32'(b4.sink_valid), 0);
    chk("t6 rst data", b4.sink_data, 0);
    chk("t6 rst id", 32'(b4.sink_id), 0);
    chk("t6 rst active", 32'(b4.grant_active), 0);
    chk("t6 rst grant_id", 32'(b4.grant_id), 0);
    chk("t6 rst ready", 32'(b4.src_ready), 0);
    src_valid = 4'b1000;
    src_data[96 +: 32] = 32'h3333_0003;
    step();
    reset = 1'b1;
    step();
    chk("t6 grant 3", 32'(b4.grant_id), 3);
    chk("t6 active", 32'(b4.grant_active), 1);
    step();
    chk("t6 out valid", 32'(b4.sink_valid), 1);
    chk("t6 out id", 32'(b4.sink_id), 3);
    chk("t6 out data", b4.sink_data, 32'h3333_0003);
    src_valid = 4'b0000;
    repeat (3) step();

    cmp_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
